spi_master_cs: RTL and testbench
================================

SPI_MASTER_CS -- requirements
Module: spi_master_cs

Interface
REQ-001 Parameter SLAVE_COUNT, default 8: number of slave chip selects.
REQ-002 Parameter DATA_WIDTH, default 8: bits per transfer.
REQ-003 Parameter CLK_DIV, default 4: system clocks per SCLK half period; legal range is 1 or greater.
REQ-004 Port clk, input, 1: system clock; all state updates occur on its rising edge.
REQ-005 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 Port start, input, 1: transfer request; it is sampled only in IDLE.
REQ-007 Port slave_sel, input, $clog2(SLAVE_COUNT): index of the target slave; it is sampled with start.
REQ-008 Port tx_data, input, DATA_WIDTH: data to send; it is sampled with start.
REQ-009 Port rx_data, output, DATA_WIDTH: received data; it holds its value until the next transfer completes.
REQ-010 Port busy, output, 1: high while a transfer is in progress.
REQ-011 Port done, output, 1: one-cycle pulse when a transfer completes.
REQ-012 Port SCLK, output, 1: SPI clock, mode 0 (idle low).
REQ-013 Port MOSI, output, 1: serial data out.
REQ-014 Port CS, output, SLAVE_COUNT: active-low chip selects; at most one bit is low at any time.
REQ-015 Port MISO, input, 1: serial data in, normally fed from the downstream MISO router output.

Function
REQ-016 The state machine SHALL have three states, IDLE, SETUP and XFER, plus the transitions defined in REQ-017 to REQ-022.
REQ-017 IDLE -> SETUP when start=1 and slave_sel<SLAVE_COUNT; tx_data SHALL be latched into the shift register on that edge, and on the following cycle busy=1, CS[slave_sel]=0 and MOSI=first bit.
REQ-018 start with slave_sel>=SLAVE_COUNT SHALL be ignored: state remains IDLE, CS stays all-ones, and no done pulse is produced.
REQ-019 SETUP SHALL last exactly CLK_DIV cycles with SCLK=0, then transition to XFER.
REQ-020 XFER: each bit SHALL occupy 2*CLK_DIV cycles, with SCLK=1 for the first CLK_DIV and SCLK=0 for the second CLK_DIV.
REQ-021 MISO SHALL be sampled into the receive shift register on the clk edge that drives SCLK 0->1; MOSI SHALL advance to the next bit on the edge that drives SCLK 1->0.
REQ-022 After the low phase of bit DATA_WIDTH-1 the block SHALL go to IDLE; on that edge CS becomes all-ones, busy=0, done=1 for one cycle, and rx_data is updated.
REQ-023 busy SHALL stay high for exactly CLK_DIV*(2*DATA_WIDTH+1) cycles per transfer (68 cycles at the defaults).
REQ-024 start asserted while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-025 start held high continuously SHALL begin a new transfer on the first IDLE cycle after done (back-to-back operation); the CS deassert gap is therefore exactly one cycle.
REQ-026 Changes to slave_sel and tx_data during busy SHALL have no effect.
REQ-027 The SCLK half-period counter SHALL be $clog2(CLK_DIV+1) bits wide and SHALL wrap to 0 at CLK_DIV-1.
REQ-028 The bit counter SHALL be $clog2(DATA_WIDTH+1) bits wide.

Reset
REQ-029 While rst_n=0, outputs SHALL be forced asynchronously to: state IDLE, CS all-ones, SCLK=0, MOSI=0, busy=0, done=0, rx_data=0, and both counters=0.
REQ-030 Reset asserted mid-transfer SHALL abort the transfer immediately with no done pulse; after release the block SHALL sit in IDLE awaiting start.

Configuration
REQ-031 Macro SPI_LSB_FIRST_EN: when defined, both tx and rx SHALL shift LSB first, so rx bit 0 is the first MISO sample.
REQ-032 Without SPI_LSB_FIRST_EN, both tx and rx SHALL shift MSB first; all other timing is identical in both builds.

Verification
REQ-033 Defaults, loopback MOSI->MISO, start with sel=2 and tx=0xA5 -> CS=8'b1111_1011 for 68 cycles, rx_data=0xA5, done pulses once.
REQ-034 MISO driven by a model returning 0x3C, sel=7, with 8 SCLK rising edges counted -> rx_data=0x3C and CS[7] is the only bit that went low.
REQ-035 start pulsed at cycle 10 of an active transfer with sel=0 -> ignored; CS[0] never asserts and exactly one done pulse occurs.
REQ-036 rst_n pulled low at bit 4 -> CS=0xFF, SCLK=0 and busy=0 in the same cycle with no done pulse; a subsequent start with tx=0x81 completes normally.
REQ-037 SPI_LSB_FIRST_EN defined, tx=0x01, loopback -> MOSI=1 during the first bit only and rx_data=0x01; start with sel=9 on SLAVE_COUNT=8 -> no activity.

Source files
------------

// File: rtl/spi_master_cs.sv
// SPI mode-0 master with per-slave active-low chip selects and a fixed SCLK divider.
// Optional build macro SPI_LSB_FIRST_EN: shift tx and rx LSB first (default MSB first).
module spi_master_cs #(
  parameter int SLAVE_COUNT = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int CLK_DIV     = 4,
  localparam int SEL_W = (SLAVE_COUNT > 1) ? $clog2(SLAVE_COUNT) : 1,
  localparam int DIV_W = $clog2(CLK_DIV + 1),
  localparam int BIT_W = $clog2(DATA_WIDTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [SEL_W-1:0]       slave_sel,
  input  logic [DATA_WIDTH-1:0]  tx_data,
  output logic [DATA_WIDTH-1:0]  rx_data,
  output logic                   busy,
  output logic                   done,
  output logic                   SCLK,
  output logic                   MOSI,
  output logic [SLAVE_COUNT-1:0] CS,
  input  logic                   MISO
);

  typedef enum logic [1:0] {IDLE, SETUP, XFER} state_t;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  state_t                  state, state_nxt;
  logic [DIV_W-1:0]        div_cnt, div_nxt;
  logic [BIT_W-1:0]        bit_cnt, bit_nxt;
  logic [DATA_WIDTH-1:0]   tx_sreg, tx_nxt, tx_shift;
  logic [DATA_WIDTH-1:0]   rx_sreg, rx_nxt, rx_shift, rx_data_nxt;
  logic [SLAVE_COUNT-1:0]  cs_nxt, cs_sel;
  logic                    sclk_nxt, done_nxt, sel_ok, div_last;

  assign busy     = (state != IDLE);
  assign div_last = (div_cnt == DIV_LAST);

  // Out-of-range selects simply fail to match any slave and are dropped.
  always_comb begin
    cs_sel = '1;
    sel_ok = 1'b0;
    for (int i = 0; i < SLAVE_COUNT; i++) begin
      if (slave_sel == SEL_W'(i)) begin
        sel_ok    = 1'b1;
        cs_sel[i] = 1'b0;
      end
    end
  end

`ifdef SPI_LSB_FIRST_EN
  assign MOSI = tx_sreg[0];
  always_comb begin
    tx_shift = tx_sreg >> 1;
    rx_shift = rx_sreg >> 1;
    rx_shift[DATA_WIDTH-1] = MISO;
  end
`else
  assign MOSI = tx_sreg[DATA_WIDTH-1];
  always_comb begin
    tx_shift = tx_sreg << 1;
    rx_shift = rx_sreg << 1;
    rx_shift[0] = MISO;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      tx_sreg <= '0;
      rx_sreg <= '0;
      rx_data <= '0;
      SCLK    <= 1'b0;
      CS      <= '1;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      div_cnt <= div_nxt;
      bit_cnt <= bit_nxt;
      tx_sreg <= tx_nxt;
      rx_sreg <= rx_nxt;
      rx_data <= rx_data_nxt;
      SCLK    <= sclk_nxt;
      CS      <= cs_nxt;
      done    <= done_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    div_nxt     = div_cnt;
    bit_nxt     = bit_cnt;
    tx_nxt      = tx_sreg;
    rx_nxt      = rx_sreg;
    rx_data_nxt = rx_data;
    sclk_nxt    = SCLK;
    cs_nxt      = CS;
    done_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (start && sel_ok) begin
          state_nxt = SETUP;
          tx_nxt    = tx_data;
          cs_nxt    = cs_sel;
          div_nxt   = '0;
          bit_nxt   = '0;
          sclk_nxt  = 1'b0;
        end
      end
      SETUP: begin
        if (div_last) begin
          div_nxt   = '0;
          state_nxt = XFER;
          sclk_nxt  = 1'b1;
          rx_nxt    = rx_shift;
        end else begin
          div_nxt = div_cnt + 1'b1;
        end
      end
      XFER: begin
        if (!div_last) begin
          div_nxt = div_cnt + 1'b1;
        end else begin
          div_nxt = '0;
          if (SCLK) begin
            sclk_nxt = 1'b0;
            tx_nxt   = tx_shift;
          end else if (bit_cnt == BIT_LAST) begin
            // rx_sreg already holds every sample; the last one was taken at this bit's rising edge.
            state_nxt   = IDLE;
            cs_nxt      = '1;
            done_nxt    = 1'b1;
            rx_data_nxt = rx_sreg;
            bit_nxt     = '0;
          end else begin
            bit_nxt  = bit_cnt + 1'b1;
            sclk_nxt = 1'b1;
            rx_nxt   = rx_shift;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_master_cs.sv
// Scoreboard bench for spi_master_cs: directed transfers push expectations, a monitor checks each done.
module tb_spi_master_cs;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] slave_sel = '0;
  logic [7:0] tx_data = '0;
  logic [7:0] rx_data;
  logic       busy, done, SCLK, MOSI, MISO;
  logic [7:0] CS;

  // Second instance: non-power-of-two slave count, CLK_DIV=1, 4-bit words.
  logic       o_start = 1'b0;
  logic [2:0] o_sel = '0;
  logic [3:0] o_tx = '0;
  logic [3:0] o_rx;
  logic       o_busy, o_done, o_sclk, o_mosi;
  logic [4:0] o_cs;

  logic       model_mode = 1'b0;
  logic [7:0] model_sreg = '0;

  always #5 clk = ~clk;

  spi_master_cs dut (
    .clk(clk), .rst_n(rst_n), .start(start), .slave_sel(slave_sel), .tx_data(tx_data),
    .rx_data(rx_data), .busy(busy), .done(done), .SCLK(SCLK), .MOSI(MOSI), .CS(CS), .MISO(MISO)
  );

  spi_master_cs #(.SLAVE_COUNT(5), .DATA_WIDTH(4), .CLK_DIV(1)) u_odd (
    .clk(clk), .rst_n(rst_n), .start(o_start), .slave_sel(o_sel), .tx_data(o_tx),
    .rx_data(o_rx), .busy(o_busy), .done(o_done), .SCLK(o_sclk), .MOSI(o_mosi), .CS(o_cs), .MISO(o_mosi)
  );

  // Slave model shifts out on SCLK falling edges; loopback otherwise.
`ifdef SPI_LSB_FIRST_EN
  assign MISO = model_mode ? model_sreg[0] : MOSI;
  always @(negedge SCLK) model_sreg <= model_sreg >> 1;
`else
  assign MISO = model_mode ? model_sreg[7] : MOSI;
  always @(negedge SCLK) model_sreg <= model_sreg << 1;
`endif

  typedef struct {
    logic [7:0] rx;
    logic [7:0] tx;
    logic [7:0] cs;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0, n_total = 0;
  int   done_cnt = 0, spurious = 0, pushed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [7:0] mosi_order(input logic [7:0] tx);
`ifdef SPI_LSB_FIRST_EN
    return tx;
`else
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = tx[7-i];
    return r;
`endif
  endfunction

  // Monitor: accumulates per-transfer observations, compares on done.
  initial begin
    logic [7:0] cs_and, cs_or, mseq;
    int         busy_cyc, rises;
    logic       sclk_q;
    exp_t       e;
    cs_and = '1; cs_or = '0; mseq = '0; busy_cyc = 0; rises = 0; sclk_q = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cs_and = '1; cs_or = '0; mseq = '0; busy_cyc = 0; rises = 0; sclk_q = 1'b0;
      end else begin
        if (busy) begin
          cs_and &= CS;
          cs_or  |= CS;
          busy_cyc++;
          if (SCLK && !sclk_q) begin
            if (rises < 8) mseq[rises] = MOSI;
            rises++;
          end
        end
        sclk_q = SCLK;
        if (done) begin
          done_cnt++;
          if (exp_q.size() == 0) spurious++;
          else begin
            e = exp_q.pop_front();
            chk("rx_data", rx_data, e.rx);
            chk("cs_and", cs_and, e.cs);
            chk("cs_or", cs_or, e.cs);
            chk("busy_cycles", busy_cyc, 68);
            chk("sclk_rises", rises, 8);
            chk("mosi_bits", mseq, mosi_order(e.tx));
            chk("cs_at_done", CS, 8'hFF);
            chk("busy_at_done", busy, 1'b0);
          end
          cs_and = '1; cs_or = '0; mseq = '0; busy_cyc = 0; rises = 0;
        end
      end
    end
  end

  task automatic push(input logic [2:0] sel, input logic [7:0] tx, input logic [7:0] rx);
    exp_t e;
    e.rx = rx; e.tx = tx; e.cs = ~(8'h01 << sel);
    exp_q.push_back(e);
    pushed++;
  endtask

  task automatic do_start(input logic [2:0] sel, input logic [7:0] tx);
    @(negedge clk);
    start = 1'b1; slave_sel = sel; tx_data = tx;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 300 && done_cnt < target; i++) @(posedge clk);
    chk("wait_done", done_cnt, target);
  endtask

  initial begin
    int ob, ocnt;
    logic od, oseen;
    logic [4:0] ocs;

    #12;
    chk("rst_cs", CS, 8'hFF);
    chk("rst_sclk", SCLK, 1'b0);
    chk("rst_mosi", MOSI, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_rx", rx_data, 8'h00);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Loopback A5 on slave 2.
    push(3'd2, 8'hA5, 8'hA5);
    do_start(3'd2, 8'hA5);
    wait_done(1);

    // Slave model returns 3C on slave 7.
    model_mode = 1'b1; model_sreg = 8'h3C;
    push(3'd7, 8'h5A, 8'h3C);
    do_start(3'd7, 8'h5A);
    wait_done(2);
    model_mode = 1'b0;

    // start while busy (sel 0) must be dropped.
    push(3'd3, 8'h96, 8'h96);
    do_start(3'd3, 8'h96);
    repeat (8) @(negedge clk);
    start = 1'b1; slave_sel = 3'd0; tx_data = 8'hFF;
    @(negedge clk); start = 1'b0;
    wait_done(3);
    repeat (80) @(negedge clk);
    chk("no_queued_start", done_cnt, 3);

    // Back-to-back with start held; inputs changed while busy.
    push(3'd1, 8'h0F, 8'h0F);
    push(3'd6, 8'hF0, 8'hF0);
    @(negedge clk); start = 1'b1; slave_sel = 3'd1; tx_data = 8'h0F;
    @(negedge clk); slave_sel = 3'd6; tx_data = 8'hF0;
    wait_done(4);
    #1 chk("b2b_gap_busy", busy, 1'b1);
    chk("b2b_cs", CS, 8'hBF);
    start = 1'b0;
    wait_done(5);

    // Reset during bit 4 aborts without done.
    do_start(3'd5, 8'h33);
    repeat (38) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_cs", CS, 8'hFF);
    chk("abort_sclk", SCLK, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    chk("abort_rx", rx_data, 8'h00);
    chk("abort_no_done", done_cnt, 5);
    push(3'd4, 8'h81, 8'h81);
    do_start(3'd4, 8'h81);
    wait_done(6);

    // LSB-only pattern exercises bit order.
    push(3'd0, 8'h01, 8'h01);
    do_start(3'd0, 8'h01);
    wait_done(7);

    // Odd instance: out-of-range selects 5 and 7 ignored.
    @(negedge clk); o_start = 1'b1; o_sel = 3'd5; o_tx = 4'hA;
    @(negedge clk); o_sel = 3'd7;
    @(negedge clk); o_start = 1'b0;
    ob = 0; od = 1'b0; ocs = '1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (o_busy) ob++;
      od |= o_done;
      ocs &= o_cs;
    end
    chk("bad_sel_busy", ob, 0);
    chk("bad_sel_done", od, 1'b0);
    chk("bad_sel_cs", ocs, 5'h1F);

    // Odd instance: highest legal select, CLK_DIV=1 timing.
    @(negedge clk); o_start = 1'b1; o_sel = 3'd4; o_tx = 4'hA;
    ocnt = 0; oseen = 1'b0; ocs = '1;
    for (int i = 0; i < 30 && !oseen; i++) begin
      @(negedge clk);
      o_start = 1'b0;
      if (o_busy) begin ocnt++; ocs &= o_cs; end
      if (o_done) oseen = 1'b1;
    end
    chk("odd_done", oseen, 1'b1);
    chk("odd_busy_cycles", ocnt, 9);
    chk("odd_rx", o_rx, 4'hA);
    chk("odd_cs", ocs, 5'h0F);

    repeat (5) @(negedge clk);
    chk("done_count", done_cnt, pushed);
    chk("spurious_done", spurious, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
